// File: rtl/eth_fifo_hsst_framer_if.sv
// FIFO read port and HSST TX lane seen by the framer.
// master: FIFO/lane side, slave: the framer.
interface eth_fifo_hsst_framer_if;
    logic        fifo_rd_vld;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_en;
    logic        link_up;
    logic [31:0] tx_data;
    logic [3:0]  tx_charisk;

    modport master (
        output fifo_rd_vld,
        output fifo_rd_data,
        input  fifo_rd_en,
        output link_up,
        input  tx_data,
        input  tx_charisk
    );

    modport slave (
        input  fifo_rd_vld,
        input  fifo_rd_data,
        output fifo_rd_en,
        input  link_up,
        output tx_data,
        output tx_charisk
    );
endinterface

// File: rtl/eth_fifo_hsst_framer.sv
// Pops length-prefixed frames from the Ethernet prefetch FIFO and emits
// K-coded SOF / payload / checksum / EOF words for the HSST TX lane.
// Malformed headers are skipped; frames cut by link loss are aborted and
// their remaining payload drained from the FIFO.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | sending comma idles, popping the next header when link is up
// PAYLOAD | forwarding payload words and accumulating the checksum
// CSUM    | sending the checksum word
// EOF     | sending EOF, bumping seq and frame_cnt
// DROP    | discarding the rest of an aborted frame
module eth_fifo_hsst_framer #(
    parameter logic [15:0] MAX_WORDS = 16'd375,
    parameter logic [31:0] IDLE_WORD = 32'h50BC_50BC,
    parameter logic [3:0]  IDLE_K    = 4'b0101,
    parameter int          CNT_W     = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    eth_fifo_hsst_framer_if.slave bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_CSUM    = 3'd2,
        S_EOF     = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    localparam logic [31:0] EOF_WORD  = 32'h0000_00FD;
    localparam logic [31:0] ABRT_WORD = 32'h0000_00FE;
    localparam logic [3:0]  K_CTRL    = 4'b0001;

    state_t            state_q, state_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic [3:0]        tx_k_q, tx_k_d;
    logic [7:0]        seq_q, seq_d;
    logic [31:0]       sum_q, sum_d;
    logic [15:0]       rem_q, rem_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              rd_en;
    logic              pop;
    logic [15:0]       hdr_len;

    // Pops are held off during reset so unread words survive in the FIFO.
    assign bus.fifo_rd_en = rd_en & ~rd_rst;
    assign pop            = rd_en & bus.fifo_rd_vld;
    assign hdr_len        = bus.fifo_rd_data[15:0];

    // Next-state, pop enable and next TX word.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = IDLE_WORD;
        tx_k_d      = IDLE_K;
        seq_d       = seq_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        rd_en       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rd_en = bus.link_up;
                if (pop) begin
                    if (hdr_len != 16'd0 && hdr_len <= MAX_WORDS) begin
                        tx_data_d = {hdr_len, seq_q, 8'hFB};
                        tx_k_d    = K_CTRL;
                        rem_d     = hdr_len;
                        sum_d     = 32'd0;
                        state_d   = S_PAYLOAD;
                    end else if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                rd_en = bus.link_up;
                if (!bus.link_up) begin
                    tx_data_d = ABRT_WORD;
                    tx_k_d    = K_CTRL;
                    state_d   = S_DROP;
                    if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
                end else if (pop) begin
                    tx_data_d = bus.fifo_rd_data;
                    tx_k_d    = 4'b0000;
                    sum_d     = sum_q + bus.fifo_rd_data;
                    rem_d     = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                tx_data_d = sum_q;
                tx_k_d    = 4'b0000;
                state_d   = S_EOF;
            end
            S_EOF: begin
                tx_data_d   = EOF_WORD;
                tx_k_d      = K_CTRL;
                seq_d       = seq_q + 8'd1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = S_IDLE;
            end
            S_DROP: begin
                rd_en = 1'b1;
                if (pop) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q     <= S_IDLE;
            tx_data_q   <= IDLE_WORD;
            tx_k_q      <= IDLE_K;
            seq_q       <= 8'd0;
            sum_q       <= 32'd0;
            rem_q       <= 16'd0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_k_q      <= tx_k_d;
            seq_q       <= seq_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_charisk = tx_k_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_cnt      = frame_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_eth_fifo_hsst_framer.sv
// Scoreboard bench for eth_fifo_hsst_framer: a queue models the FIFO, the
// expected non-idle TX words are queued as frames are loaded and checked
// in order as the framer emits them.
module tb_eth_fifo_hsst_framer;
    localparam logic [31:0] IDLE_W = 32'h50BC_50BC;
    localparam logic [3:0]  IDLE_K = 4'b0101;
    localparam logic [35:0] EOF_P  = {4'b0001, 32'h0000_00FD};
    localparam logic [35:0] ABRT_P = {4'b0001, 32'h0000_00FE};

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    eth_fifo_hsst_framer_if bus ();

    eth_fifo_hsst_framer dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    logic [31:0] fifo_q[$];
    logic [35:0] exp_q[$];
    logic        stall = 1'b0;
    logic [7:0]  exp_seq = 8'd0;
    logic        in_frame = 1'b0;
    int          idle_in_frame = 0;
    int          b2b_cnt = 0;
    logic [35:0] last_obs = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive FIFO head at negedge, note pop before the edge,
    // retire the popped word and score the TX word after the edge.
    task automatic tick();
        logic        popped;
        logic [35:0] obs;
        logic [35:0] e;
        bus.fifo_rd_vld  = (fifo_q.size() != 0) && !stall;
        bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
        #4;
        popped = bus.fifo_rd_en && bus.fifo_rd_vld;
        @(posedge rd_clk);
        #1;
        if (popped) void'(fifo_q.pop_front());
        obs = {bus.tx_charisk, bus.tx_data};
        if (obs == {IDLE_K, IDLE_W}) begin
            if (in_frame) idle_in_frame++;
        end else begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tx", obs, {IDLE_K, IDLE_W});
            end else begin
                e = exp_q.pop_front();
                chk("tx_word", obs, e);
            end
            if (obs[35:32] == 4'b0001 && obs[7:0] == 8'hFB) begin
                if (last_obs == EOF_P) b2b_cnt++;
                in_frame = 1'b1;
            end
            if (obs == EOF_P || obs == ABRT_P) in_frame = 1'b0;
        end
        last_obs = obs;
        @(negedge rd_clk);
    endtask

    task automatic exp_push(input logic [3:0] k, input logic [31:0] d);
        exp_q.push_back({k, d});
    endtask

    // Loads one legal frame with random payload and queues its TX words.
    task automatic push_frame(input logic [15:0] len);
        logic [31:0] w;
        logic [31:0] s;
        s = 32'd0;
        fifo_q.push_back({16'($urandom), len});
        exp_push(4'b0001, {len, exp_seq, 8'hFB});
        for (int i = 0; i < int'(len); i++) begin
            w = $urandom;
            s = s + w;
            fifo_q.push_back(w);
            exp_push(4'b0000, w);
        end
        exp_push(4'b0000, s);
        exp_push(4'b0001, 32'h0000_00FD);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic wait_fifo_empty(input int budget);
        for (int i = 0; i < budget && fifo_q.size() != 0; i++) tick();
        chk("fifo_drained", 36'(fifo_q.size()), 36'd0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        chk("exp_left", 36'(exp_q.size()), 36'd0);
    endtask

    task automatic do_reset();
        fifo_q.delete();
        exp_q.delete();
        exp_seq       = 8'd0;
        in_frame      = 1'b0;
        idle_in_frame = 0;
        b2b_cnt       = 0;
        bus.link_up   = 1'b1;
        rd_rst        = 1'b1;
        repeat (2) tick();
        rd_rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a, b, c;
        bus.link_up      = 1'b1;
        bus.fifo_rd_vld  = 1'b0;
        bus.fifo_rd_data = 32'd0;
        @(negedge rd_clk);

        // 1: reset state, single frame, then seq=1 on the next frame
        do_reset();
        chk("rst_tx", {bus.tx_charisk, bus.tx_data}, {IDLE_K, IDLE_W});
        chk("rst_busy", 36'(busy), 36'd0);
        chk("rst_frame_cnt", 36'(frame_cnt), 36'd0);
        chk("rst_err_cnt", 36'(err_cnt), 36'd0);
        a = 32'h1111_2222;
        b = 32'hF000_0003;
        fifo_q.push_back(32'h0000_0002);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        exp_push(4'b0001, 32'h0002_00FB);
        exp_push(4'b0000, a);
        exp_push(4'b0000, b);
        exp_push(4'b0000, a + b);
        exp_push(4'b0001, 32'h0000_00FD);
        exp_seq = 8'd1;
        drain(30);
        chk("t1_frame_cnt", 36'(frame_cnt), 36'd1);
        chk("t1_busy", 36'(busy), 36'd0);
        push_frame(16'd3);
        drain(30);
        chk("t1_frame_cnt2", 36'(frame_cnt), 36'd2);

        // 2: FIFO empty for 3 cycles between payload words 1 and 2
        do_reset();
        a = $urandom; b = $urandom; c = $urandom;
        fifo_q.push_back(32'h0000_0003);
        fifo_q.push_back(a);
        exp_push(4'b0001, 32'h0003_00FB);
        exp_push(4'b0000, a);
        exp_push(4'b0000, b);
        exp_push(4'b0000, c);
        exp_push(4'b0000, a + b + c);
        exp_push(4'b0001, 32'h0000_00FD);
        wait_fifo_empty(20);
        repeat (3) tick();
        fifo_q.push_back(b);
        fifo_q.push_back(c);
        drain(30);
        chk("t2_idle_fill", 36'(idle_in_frame), 36'd3);
        chk("t2_frame_cnt", 36'(frame_cnt), 36'd1);

        // 3: bad headers len=0 and len=376 are skipped, next frame normal
        do_reset();
        fifo_q.push_back(32'hABCD_0000);
        fifo_q.push_back(32'h0000_0178);
        push_frame(16'd2);
        drain(30);
        chk("t3_err_cnt", 36'(err_cnt), 36'd2);
        chk("t3_frame_cnt", 36'(frame_cnt), 36'd1);

        // 3b: boundary lengths 1 and MAX_WORDS are legal
        do_reset();
        push_frame(16'd1);
        push_frame(16'd375);
        drain(500);
        chk("t3b_err_cnt", 36'(err_cnt), 36'd0);
        chk("t3b_frame_cnt", 36'(frame_cnt), 36'd2);

        // 4: link drops after 2 of 5 payload words
        do_reset();
        fifo_q.push_back(32'h0000_0005);
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        exp_push(4'b0001, 32'h0005_00FB);
        exp_push(4'b0000, fifo_q[1]);
        exp_push(4'b0000, fifo_q[2]);
        exp_push(4'b0001, 32'h0000_00FE);
        wait_fifo_empty(20);
        tick();
        bus.link_up = 1'b0;
        tick();
        chk("t4_abrt", {bus.tx_charisk, bus.tx_data}, ABRT_P);
        chk("t4_err_now", 36'(err_cnt), 36'd1);
        repeat (3) fifo_q.push_back($urandom);
        wait_fifo_empty(20);
        drain(10);
        chk("t4_busy", 36'(busy), 36'd0);
        chk("t4_err_cnt", 36'(err_cnt), 36'd1);
        chk("t4_frame_cnt", 36'(frame_cnt), 36'd0);
        bus.link_up = 1'b1;

        // 5: back-to-back frames, seq wraps after 256 frames
        do_reset();
        for (int i = 0; i < 257; i++) push_frame(16'd1);
        drain(1200);
        chk("t5_b2b", 36'(b2b_cnt), 36'd256);
        chk("t5_frame_cnt", 36'(frame_cnt), 36'd257);

        // 6: reset in PAYLOAD drops the frame, unread words stay queued
        do_reset();
        fifo_q.push_back(32'h0000_0004);
        fifo_q.push_back($urandom);
        exp_push(4'b0001, 32'h0004_00FB);
        exp_push(4'b0000, fifo_q[1]);
        wait_fifo_empty(20);
        tick();
        chk("t6_busy_pre", 36'(busy), 36'd1);
        chk("t6_cnt_pre", 36'(frame_cnt), 36'd1 - 36'd1);
        fifo_q.push_back(32'h1234_5678);
        fifo_q.push_back(32'h9ABC_DEF0);
        rd_rst = 1'b1;
        tick();
        rd_rst = 1'b0;
        chk("t6_tx", {bus.tx_charisk, bus.tx_data}, {IDLE_K, IDLE_W});
        chk("t6_busy", 36'(busy), 36'd0);
        chk("t6_frame_cnt", 36'(frame_cnt), 36'd0);
        chk("t6_err_cnt", 36'(err_cnt), 36'd0);
        chk("t6_fifo_kept", 36'(fifo_q.size()), 36'd2);
        chk("t6_exp_left", 36'(exp_q.size()), 36'd0);
        fifo_q.delete();
        in_frame = 1'b0;
        exp_seq  = 8'd0;
        push_frame(16'd2);
        drain(30);
        chk("t6_frame_cnt_after", 36'(frame_cnt), 36'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
